// File: rtl/huff_pkg.sv
// Shared types and sizing helpers for the parametrised Huffman code generator.
package huff_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUILD, S_QUERY, S_EMIT} state_t;

  // Marks "no node found" out of the two-minimum search.
  localparam logic [31:0] LEAF_NONE = '1;

  function automatic int node_cnt(input int n_sym);
    return 2 * n_sym - 1;
  endfunction

  function automatic int id_w(input int n_sym);
    return $clog2(2 * n_sym - 1);
  endfunction
endpackage

// File: rtl/huff_codec_param_if.sv
// Load, query and code-stream handshakes of the Huffman code generator.
interface huff_codec_param_if #(
  parameter int N_SYM = 8,
  parameter int W_W   = 3,
  parameter int SYM_W = $clog2(N_SYM)
) ();
  logic             in_valid;
  logic [W_W-1:0]   in_weight;
  logic             in_ready;
  logic             q_valid;
  logic [SYM_W-1:0] q_sym;
  logic             q_last;
  logic             q_ready;
  logic             out_valid;
  logic             out_code;
  logic             out_last;
  logic             out_err;
  logic             done;

  modport master (
    output in_valid, in_weight, q_valid, q_sym, q_last,
    input  in_ready, q_ready, out_valid, out_code, out_last, out_err, done
  );
  modport slave (
    input  in_valid, in_weight, q_valid, q_sym, q_last,
    output in_ready, q_ready, out_valid, out_code, out_last, out_err, done
  );
endinterface

// File: rtl/huff_min2.sv
// Combinational search for the two smallest live nodes; equal weights rank the
// higher node id as smaller.
module huff_min2 #(
  parameter int N_NODE = 15,
  parameter int ID_W   = 4,
  parameter int SUM_W  = 6
) (
  input  logic [N_NODE-1:0][SUM_W-1:0] wt,
  input  logic [N_NODE-1:0]            live,
  output logic [ID_W-1:0]              s1,
  output logic [ID_W-1:0]              s2
);
  import huff_pkg::*;

  logic [SUM_W-1:0] w1, w2;
  logic             h1, h2;

  // Ascending scan with <= lets a later (higher) id win every tie.
  always_comb begin
    s1 = ID_W'(LEAF_NONE);
    s2 = ID_W'(LEAF_NONE);
    w1 = '0;
    w2 = '0;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int j = 0; j < N_NODE; j++) begin
      if (live[j]) begin
        if (!h1 || wt[j] <= w1) begin
          s2 = s1;
          w2 = w1;
          h2 = h1;
          s1 = ID_W'(j);
          w1 = wt[j];
          h1 = 1'b1;
        end else if (!h2 || wt[j] <= w2) begin
          s2 = ID_W'(j);
          w2 = wt[j];
          h2 = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/huff_codec_param.sv
// Huffman code generator: serial weight load, one merge per cycle, then
// serial root-first code streaming for any sequence of symbol queries.
module huff_codec_param #(
  parameter int N_SYM = 8,
  parameter int W_W   = 3,
  parameter int SYM_W = $clog2(N_SYM)
) (
  input  logic               clk,
  input  logic               rst,
  huff_codec_param_if.slave  bus
);
  import huff_pkg::*;

  localparam int SUM_W  = W_W + SYM_W;
  localparam int CODE_W = N_SYM - 1;
  localparam int N_NODE = node_cnt(N_SYM);
  localparam int ID_W   = id_w(N_SYM);
  localparam int IX_W   = $clog2(N_SYM);
  localparam int LEN_W  = $clog2(CODE_W + 1);

  state_t                          state;
  logic [IX_W-1:0]                 lcnt;
  logic [ID_W-1:0]                 nid;
  logic [LEN_W-1:0]                bcnt;
  logic [IX_W-1:0]                 qs;
  logic                            qlast;
  logic [N_NODE-1:0][SUM_W-1:0]    wt;
  logic [N_NODE-1:0]               live;
  logic [N_SYM-1:0][N_NODE-1:0]    mem;
  logic [N_SYM-1:0][CODE_W-1:0]    code;
  logic [N_SYM-1:0][LEN_W-1:0]     len;
  logic [ID_W-1:0]                 s1, s2;
  logic [IX_W-1:0]                 qi;

  assign qi = bus.q_sym[IX_W-1:0];

  huff_min2 #(.N_NODE(N_NODE), .ID_W(ID_W), .SUM_W(SUM_W)) u_min2 (
    .wt(wt), .live(live), .s1(s1), .s2(s2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.q_ready   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_code  <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.done      <= 1'b0;
      lcnt  <= '0;
      nid   <= '0;
      bcnt  <= '0;
      qs    <= '0;
      qlast <= 1'b0;
      wt    <= '0;
      live  <= '0;
      mem   <= '0;
      code  <= '0;
      len   <= '0;
    end else begin
      bus.out_err <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: if (bus.in_valid) begin
          // Each beat reinitialises its leaf, so nothing leaks from the previous session.
          if (state == S_IDLE)
            for (int j = N_SYM; j < N_NODE; j++) live[j] <= 1'b0;
          wt[ID_W'(lcnt)]        <= SUM_W'(bus.in_weight);
          live[ID_W'(lcnt)]      <= 1'b1;
          mem[lcnt]              <= '0;
          mem[lcnt][ID_W'(lcnt)] <= 1'b1;
          code[lcnt]             <= '0;
          len[lcnt]              <= '0;
          if (lcnt == IX_W'(N_SYM - 1)) begin
            lcnt         <= '0;
            nid          <= ID_W'(N_SYM);
            bus.in_ready <= 1'b0;
            state        <= S_BUILD;
          end else begin
            lcnt  <= lcnt + 1'b1;
            state <= S_LOAD;
          end
        end
        S_BUILD: begin
          wt[nid]   <= wt[s1] + wt[s2];
          live[s1]  <= 1'b0;
          live[s2]  <= 1'b0;
          live[nid] <= 1'b1;
          // Bits are appended at index len, so the root bit ends up at len-1.
          for (int i = 0; i < N_SYM; i++) begin
            if (mem[i][s1]) begin
              code[i][len[i]] <= 1'b1;
              len[i]          <= len[i] + 1'b1;
              mem[i][nid]     <= 1'b1;
            end else if (mem[i][s2]) begin
              code[i][len[i]] <= 1'b0;
              len[i]          <= len[i] + 1'b1;
              mem[i][nid]     <= 1'b1;
            end
          end
          nid <= nid + 1'b1;
          if (nid == ID_W'(N_NODE - 1)) begin
            bus.q_ready <= 1'b1;
            state       <= S_QUERY;
          end
        end
        S_QUERY: if (bus.q_valid) begin
          bus.q_ready <= 1'b0;
          qlast       <= bus.q_last;
          if (int'(bus.q_sym) >= N_SYM) begin
            bus.out_err <= 1'b1;
            bcnt        <= '0;
            if (bus.q_last) begin
              bus.done     <= 1'b1;
              bus.in_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              state <= S_EMIT;
            end
          end else begin
            qs            <= qi;
            bus.out_valid <= 1'b1;
            bus.out_code  <= code[qi][len[qi] - 1'b1];
            bus.out_last  <= (len[qi] == LEN_W'(1));
            bcnt          <= len[qi] - 1'b1;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bcnt == '0) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (qlast) begin
              bus.done     <= 1'b1;
              bus.in_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              bus.q_ready <= 1'b1;
              state       <= S_QUERY;
            end
          end else begin
            bus.out_code <= code[qs][bcnt - 1'b1];
            bus.out_last <= (bcnt == LEN_W'(1));
            bcnt         <= bcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_codec_param.sv
// Directed bench: an N_SYM=4 and an N_SYM=8 (SYM_W=4) instance share one stimulus
// driver; sel picks which instance is driven and observed.
module tb_huff_codec_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huff_codec_param_if #(.N_SYM(4), .W_W(3), .SYM_W(2)) b4 ();
  huff_codec_param_if #(.N_SYM(8), .W_W(3), .SYM_W(4)) b8 ();

  huff_codec_param #(.N_SYM(4), .W_W(3), .SYM_W(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
  huff_codec_param #(.N_SYM(8), .W_W(3), .SYM_W(4)) u8 (.clk(clk), .rst(rst), .bus(b8));

  logic       sel, iv, qv, ql;
  logic [2:0] iw;
  logic [3:0] qs;

  assign b4.in_valid  = iv & ~sel;
  assign b8.in_valid  = iv & sel;
  assign b4.in_weight = iw;
  assign b8.in_weight = iw;
  assign b4.q_valid   = qv & ~sel;
  assign b8.q_valid   = qv & sel;
  assign b4.q_sym     = qs[1:0];
  assign b8.q_sym     = qs;
  assign b4.q_last    = ql;
  assign b8.q_last    = ql;

  wire o_in_ready  = sel ? b8.in_ready  : b4.in_ready;
  wire o_q_ready   = sel ? b8.q_ready   : b4.q_ready;
  wire o_out_valid = sel ? b8.out_valid : b4.out_valid;
  wire o_out_code  = sel ? b8.out_code  : b4.out_code;
  wire o_out_last  = sel ? b8.out_last  : b4.out_last;
  wire o_out_err   = sel ? b8.out_err   : b4.out_err;
  wire o_done      = sel ? b8.done      : b4.done;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_irdy"}, o_in_ready, 1);
    chk({tag, "_qrdy"}, o_q_ready, 0);
    chk({tag, "_ov"},   o_out_valid, 0);
    chk({tag, "_ol"},   o_out_last, 0);
    chk({tag, "_err"},  o_out_err, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  task automatic load(input int n, input logic [7:0][2:0] w, input bit gaps, input string tag);
    chk({tag, "_irdy"}, o_in_ready, 1);
    for (int k = 0; k < n; k++) begin
      iv = 1'b1;
      iw = w[k];
      @(posedge clk); #1;
      if (gaps) begin
        iv = 1'b0;
        @(posedge clk); #1;
      end
    end
    iv = 1'b0;
    chk({tag, "_irdy_off"}, o_in_ready, 0);
  endtask

  task automatic wait_qrdy(input string tag);
    int n = 0;
    while (!o_q_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_qrdy"}, o_q_ready, 1);
  endtask

  task automatic query(input logic [3:0] sym, input logic last, input logic [7:0] code,
                       input int len, input string tag);
    wait_qrdy(tag);
    qv = 1'b1; qs = sym; ql = last;
    @(posedge clk); #1;
    qv = 1'b0; ql = 1'b0;
    for (int k = len - 1; k >= 0; k--) begin
      chk($sformatf("%s_v%0d", tag, k), o_out_valid, 1);
      chk($sformatf("%s_b%0d", tag, k), o_out_code, code[k]);
      chk($sformatf("%s_l%0d", tag, k), o_out_last, (k == 0));
      @(posedge clk); #1;
    end
    chk({tag, "_vend"}, o_out_valid, 0);
    chk({tag, "_qrdy_back"}, o_q_ready, !last);
    chk({tag, "_done"}, o_done, last);
    if (last) chk({tag, "_irdy"}, o_in_ready, 1);
  endtask

  task automatic qerr(input logic [3:0] sym, input logic last, input string tag);
    logic d;
    wait_qrdy(tag);
    qv = 1'b1; qs = sym; ql = last;
    @(posedge clk); #1;
    qv = 1'b0; ql = 1'b0;
    chk({tag, "_err"}, o_out_err, 1);
    chk({tag, "_ov"},  o_out_valid, 0);
    d = o_done;
    @(posedge clk); #1;
    d = d | o_done;
    chk({tag, "_err_off"}, o_out_err, 0);
    chk({tag, "_ov2"},     o_out_valid, 0);
    chk({tag, "_done"},    d, last);
    if (last) chk({tag, "_irdy"}, o_in_ready, 1);
    else      chk({tag, "_qrdy2"}, o_q_ready, 1);
  endtask

  logic [7:0] c8 [8] = '{8'b010, 8'b011, 8'b000, 8'b001, 8'b110, 8'b111, 8'b100, 8'b101};

  initial begin
    rst = 1'b1; sel = 1'b0; iv = 1'b0; qv = 1'b0; ql = 1'b0; iw = '0; qs = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_chk("rst4");
    sel = 1'b1;
    idle_chk("rst8");

    // N_SYM=4, weights 1,2,3,4
    sel = 1'b0;
    load(4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, "t1_ld");
    query(4'd0, 1'b0, 8'b011, 3, "t1_s0");
    query(4'd1, 1'b0, 8'b010, 3, "t1_s1");
    query(4'd2, 1'b0, 8'b00,  2, "t1_s2");
    query(4'd3, 1'b1, 8'b1,   1, "t1_s3");

    // N_SYM=8, all weights 1, gap-free load
    sel = 1'b1;
    load(8, {8{3'd1}}, 1'b0, "t2_ld");
    for (int s = 0; s < 8; s++)
      query(4'(s), (s == 7), c8[s], 3, $sformatf("t2_s%0d", s));

    // Same weights with gapped beats; in_valid held high through build and queries
    load(8, {8{3'd1}}, 1'b1, "t4_ld");
    iv = 1'b1; iw = 3'd7;
    for (int s = 0; s < 7; s++)
      query(4'(s), 1'b0, c8[s], 3, $sformatf("t4_s%0d", s));
    iv = 1'b0;
    query(4'd7, 1'b1, c8[7], 3, "t4_s7");

    // Degenerate weights: one heavy symbol, a chain of zero-weight leaves
    load(8, {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b0, "t3_ld");
    query(4'd7, 1'b0, 8'b0,       1, "t3_s7");
    query(4'd6, 1'b0, 8'b1111111, 7, "t3_s6");
    query(4'd5, 1'b0, 8'b1111110, 7, "t3_s5");
    query(4'd0, 1'b0, 8'b10,      2, "t3_s0");

    // Out-of-range symbol
    qerr(4'd9, 1'b0, "t5_err");
    qerr(4'd9, 1'b1, "t5_errlast");

    // Reset in the middle of a code stream
    load(8, {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 1'b0, "t6_ld");
    wait_qrdy("t6_pre");
    qv = 1'b1; qs = 4'd6; ql = 1'b0;
    @(posedge clk); #1;
    qv = 1'b0;
    chk("t6_emit_b0", o_out_valid, 1);
    @(posedge clk); #1;
    chk("t6_emit_b1", o_out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_chk("t6_rst");
    load(8, {8{3'd1}}, 1'b0, "t6_ld2");
    query(4'd0, 1'b0, c8[0], 3, "t6_s0");
    query(4'd5, 1'b0, c8[5], 3, "t6_s5");
    query(4'd7, 1'b1, c8[7], 3, "t6_s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
